// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: state encoding,
// the register-zero constant and the load-use match helper.
package hazard_stall_unit_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load in EX whose destination is read by the ID instruction; $0 never matches.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        logic hit;
        hit = 1'b0;
        if (ex_mem_read && (ex_rt != REG_ZERO)) begin
            hit = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {CNT_W{1'b0}};
        end else if (clear) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubble, taken-branch flush and data-memory freeze control for the
// 5-stage pipeline, with a memory-access timeout and a stall-cycle counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_Register_Rs,
    input  logic [4:0]       IF_ID_Register_Rt,
    input  logic             IF_ID_Uses_Rt,
    input  logic [4:0]       ID_EX_Register_Rt,
    input  logic             ID_EX_MemRead,
    input  logic             EX_Branch_Taken,
    input  logic             EX_MEM_MemAccess,
    input  logic             Dmem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic             Mem_Error,
    output logic [CNT_W-1:0] Stall_Cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state_r;
    state_t              state_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_s;
    logic                mem_error_r;
    logic                mem_error_s;
    logic                abort_r;
    logic                abort_s;
    logic                load_use_s;
    logic                mem_stall_s;
    logic                pc_write_s;
    logic                if_id_write_s;
    logic                if_id_flush_s;
    logic                id_ex_bubble_s;
    logic                pipe_freeze_s;
    logic                stall_inc_s;

    assign load_use_s = load_use_hit(ID_EX_MemRead, ID_EX_Register_Rt,
                                     IF_ID_Register_Rs, IF_ID_Register_Rt,
                                     IF_ID_Uses_Rt);
    // After a timeout the abandoned access is considered done for one cycle.
    assign mem_stall_s = EX_MEM_MemAccess && !Dmem_Ready && !abort_r;

    // State, wait counter, abort marker and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= RUN;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            mem_error_r <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            mem_error_r <= mem_error_s;
            abort_r     <= abort_s;
        end
    end

    // Next-state and hazard controls, in priority order within RUN.
    always_comb begin
        state_s        = state_r;
        wait_cnt_s     = wait_cnt_r;
        mem_error_s    = mem_error_r;
        abort_s        = 1'b0;
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        pipe_freeze_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    pipe_freeze_s = 1'b1;
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    state_s       = MEM_WAIT;
                    wait_cnt_s    = WAIT_W'(1);
                end else if (EX_Branch_Taken) begin
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end else if (load_use_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            MEM_WAIT: begin
                pipe_freeze_s = 1'b1;
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                if (Dmem_Ready) begin
                    state_s    = RUN;
                    wait_cnt_s = {WAIT_W{1'b0}};
                end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
                    state_s     = RUN;
                    wait_cnt_s  = {WAIT_W{1'b0}};
                    mem_error_s = 1'b1;
                    abort_s     = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            default: begin
                state_s    = RUN;
                wait_cnt_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // During reset the pipeline is released rather than held by stale inputs.
    assign PC_Write     = rst_i ? pc_write_s     : 1'b1;
    assign IF_ID_Write  = rst_i ? if_id_write_s  : 1'b1;
    assign IF_ID_Flush  = rst_i ? if_id_flush_s  : 1'b0;
    assign ID_EX_Bubble = rst_i ? id_ex_bubble_s : 1'b0;
    assign Pipe_Freeze  = rst_i ? pipe_freeze_s  : 1'b0;
    assign Mem_Error    = mem_error_r;

    assign stall_inc_s = !PC_Write || Pipe_Freeze;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .clear (1'b0),
        .inc   (stall_inc_s),
        .count (Stall_Cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a vector table for RUN-state hazards
// plus sequences for memory wait, timeout, reset mid-wait and counter saturation.
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst_i;
    logic [4:0]  rs, rt, ex_rt;
    logic        uses_rt, mr, br, ma, rdy;
    logic        pc, ifw, fl, bb, fz, merr;
    logic [15:0] cnt;
    logic        s_pc, s_ifw, s_fl, s_bb, s_fz, s_merr;
    logic [3:0]  s_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .IF_ID_Register_Rs(rs), .IF_ID_Register_Rt(rt), .IF_ID_Uses_Rt(uses_rt),
        .ID_EX_Register_Rt(ex_rt), .ID_EX_MemRead(mr), .EX_Branch_Taken(br),
        .EX_MEM_MemAccess(ma), .Dmem_Ready(rdy),
        .PC_Write(pc), .IF_ID_Write(ifw), .IF_ID_Flush(fl), .ID_EX_Bubble(bb),
        .Pipe_Freeze(fz), .Mem_Error(merr), .Stall_Cycles(cnt)
    );

    hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst_i),
        .IF_ID_Register_Rs(rs), .IF_ID_Register_Rt(rt), .IF_ID_Uses_Rt(uses_rt),
        .ID_EX_Register_Rt(ex_rt), .ID_EX_MemRead(mr), .EX_Branch_Taken(br),
        .EX_MEM_MemAccess(ma), .Dmem_Ready(rdy),
        .PC_Write(s_pc), .IF_ID_Write(s_ifw), .IF_ID_Flush(s_fl), .ID_EX_Bubble(s_bb),
        .Pipe_Freeze(s_fz), .Mem_Error(s_merr), .Stall_Cycles(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic [4:0]  ex_rt;
        logic        mr;
        logic        br;
        logic        ma;
        logic        rdy;
        logic        pc;
        logic        ifw;
        logic        fl;
        logic        bb;
        logic        fz;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic e_pc, input logic e_ifw,
                           input logic e_fl, input logic e_bb, input logic e_fz);
        chk({tag, "_pc"},  {31'd0, pc},  {31'd0, e_pc});
        chk({tag, "_ifw"}, {31'd0, ifw}, {31'd0, e_ifw});
        chk({tag, "_fl"},  {31'd0, fl},  {31'd0, e_fl});
        chk({tag, "_bb"},  {31'd0, bb},  {31'd0, e_bb});
        chk({tag, "_fz"},  {31'd0, fz},  {31'd0, e_fz});
    endtask

    task automatic clear_inputs();
        rs = 5'd0; rt = 5'd0; uses_rt = 1'b0; ex_rt = 5'd0;
        mr = 1'b0; br = 1'b0; ma = 1'b0; rdy = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rs     rt     urt   ex_rt  mr    br    ma    rdy   pc    ifw   fl    bb    fz    cnt
        vecs[0]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[1]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[3]  = '{5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[4]  = '{5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[5]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
        vecs[6]  = '{5'd3, 5'd4, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
        vecs[7]  = '{5'd3, 5'd4, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[8]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
        vecs[9]  = '{5'd3, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
        vecs[10] = '{5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};

        // Reset with a live load-use on the inputs: pipeline must still be released.
        rst_i = 1'b0;
        clear_inputs();
        rs = 5'd8; ex_rt = 5'd8; mr = 1'b1;
        #2;
        chk_ctl("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_merr", {31'd0, merr}, 32'd0);
        chk("reset_cnt", {16'd0, cnt}, 32'd0);
        #10;
        clear_inputs();
        rst_i = 1'b1;
        next_cycle();
        chk("idle_cnt", {16'd0, cnt}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            rs = vecs[i].rs; rt = vecs[i].rt; uses_rt = vecs[i].uses_rt;
            ex_rt = vecs[i].ex_rt; mr = vecs[i].mr; br = vecs[i].br;
            ma = vecs[i].ma; rdy = vecs[i].rdy;
            @(negedge clk);
            chk_ctl($sformatf("v%0d", i), vecs[i].pc, vecs[i].ifw, vecs[i].fl,
                    vecs[i].bb, vecs[i].fz);
            next_cycle();
            chk($sformatf("v%0d_cnt", i), {16'd0, cnt}, {16'd0, vecs[i].cnt});
        end

        // Memory wait: 3 not-ready cycles then ready -> 4 frozen cycles; branch and load-use ignored.
        clear_inputs();
        ma = 1'b1; br = 1'b1; rs = 5'd8; ex_rt = 5'd8; mr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdy = (i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk_ctl($sformatf("mw%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk_ctl("mw_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mw_cnt", {16'd0, cnt}, 32'd7);
        chk("mw_merr", {31'd0, merr}, 32'd0);
        next_cycle();

        // Timeout with MEM_TIMEOUT=4: 5 frozen cycles, then sticky Mem_Error.
        ma = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("to%0d_fz", i), {31'd0, fz}, 32'd1);
            chk($sformatf("to%0d_merr", i), {31'd0, merr}, 32'd0);
            next_cycle();
        end
        chk("to_merr_set", {31'd0, merr}, 32'd1);
        chk("to_cnt", {16'd0, cnt}, 32'd12);
        @(negedge clk);
        chk_ctl("to_abort", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        ma = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk($sformatf("to_sticky%0d", i), {31'd0, merr}, 32'd1);
        end
        chk("to_cnt_hold", {16'd0, cnt}, 32'd12);

        // Async reset in the middle of a wait clears everything at once.
        ma = 1'b1; rdy = 1'b0;
        next_cycle();
        next_cycle();
        chk("rw_fz", {31'd0, fz}, 32'd1);
        #2;
        rst_i = 1'b0;
        ma = 1'b0;
        #1;
        chk("rw_merr", {31'd0, merr}, 32'd0);
        chk("rw_cnt", {16'd0, cnt}, 32'd0);
        chk_ctl("rw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        rst_i = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_ctl("rw_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk("rw_cnt0", {16'd0, cnt}, 32'd0);

        // Saturation: 20 load-use stall cycles on a 4-bit counter.
        rs = 5'd12; ex_rt = 5'd12; mr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (i == 14) chk("sat_15", {28'd0, s_cnt}, 32'hF);
        end
        chk("sat_hold", {28'd0, s_cnt}, 32'hF);
        chk("sat_wide", {16'd0, cnt}, 32'd20);
        clear_inputs();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard and stall controller for the 5-stage MIPS pipeline. It is the stalling counterpart to the EX-stage operand forwarding path: it handles every hazard forwarding cannot cover.
- Inserts a one-cycle bubble on a load-use dependency.
- Flushes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a timeout.

It sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable, flush and bubble controls plus the PC write enable.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum number of MEM_WAIT cycles before the access is aborted.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- IF_ID_Register_Rs  input  5  rs field of the instruction in ID.
- IF_ID_Register_Rt  input  5  rt field of the instruction in ID.
- IF_ID_Uses_Rt  input  1  the ID instruction reads rt as a source (R-type, branch, store).
- ID_EX_Register_Rt  input  5  destination rt of the instruction in EX.
- ID_EX_MemRead  input  1  the EX instruction is a load.
- EX_Branch_Taken  input  1  a branch resolved taken in EX this cycle.
- EX_MEM_MemAccess  input  1  the MEM-stage instruction is a load or store.
- Dmem_Ready  input  1  data memory completes the access this cycle.
- PC_Write  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register load enable.
- IF_ID_Flush  output  1  zero the IF/ID register.
- ID_EX_Bubble  output  1  load control zeros into ID/EX.
- Pipe_Freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- Mem_Error  output  1  sticky flag: a memory access timed out.
- Stall_Cycles  output  CNT_W  saturating count of stalled or frozen cycles.

## Operation
State machine: RUN, MEM_WAIT. The state register and counters are cleared by asynchronous reset.

Outputs are combinational from the state and the inputs. Conditions in RUN are evaluated in priority order:
1. **Memory stall**: EX_MEM_MemAccess and not Dmem_Ready. Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, no flush, no bubble. Next state is MEM_WAIT and wait_cnt loads 1.
2. **Branch flush**: EX_Branch_Taken. IF_ID_Flush=1 and ID_EX_Bubble=1. PC_Write=1 so the branch target is loaded. A load-use match in the same cycle is ignored, because its instruction is flushed.
3. **Load-use**: ID_EX_MemRead, ID_EX_Register_Rt != 0, and either ID_EX_Register_Rt == IF_ID_Register_Rs, or IF_ID_Uses_Rt and ID_EX_Register_Rt == IF_ID_Register_Rt. PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
4. **Otherwise**: PC_Write=1, IF_ID_Write=1, all other controls 0.

MEM_WAIT:
- All controls are frozen as in condition 1, and EX_Branch_Taken and the load-use match are ignored.
- When Dmem_Ready=1, the freeze is still asserted that cycle, the access completes, and the next state is RUN.
- Otherwise wait_cnt increments. When wait_cnt == MEM_TIMEOUT and Dmem_Ready=0:
  - Mem_Error is set.
  - The next state is RUN, where the remaining EX_MEM_MemAccess is treated as complete. The MEM stage squashes it on Mem_Error.
  - Mem_Error is sticky and only reset clears it.

Stall_Cycles increments on every cycle where PC_Write=0 or Pipe_Freeze=1, and saturates at all-ones with no wrap. Flush-only cycles are not counted.

Register $0 never causes a load-use stall.

## Timing
- Reset (rst_i=0): state=RUN, wait_cnt=0, Mem_Error=0, Stall_Cycles=0. While in reset, PC_Write=1 and IF_ID_Write=1; IF_ID_Flush, ID_EX_Bubble and Pipe_Freeze are 0.
- Reset asserted in MEM_WAIT returns to RUN immediately. No error is flagged.
- Load-use costs exactly one stall cycle. The next cycle the load is in MEM, ID_EX_MemRead for the stalled pair is 0, and the pipeline advances.
- A memory stall of N not-ready cycles plus the ready cycle gives N+1 frozen cycles in total.
- A timeout gives exactly MEM_TIMEOUT+1 frozen cycles, then Mem_Error=1 from the next rising edge.
- Zero combinational paths from clk_i to outputs beyond state, Mem_Error and Stall_Cycles.

## Structure
- Shared pipeline package: state encoding (RUN=0, MEM_WAIT=1) and the register-zero constant (5'd0).
- Single module, with no sub-module beyond the counter logic.
- Optional sub-module `sat_counter` (CNT_W, inc, clear), reusable by other performance counters.

## Test plan
- **Load-use**: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; Stall_Cycles 0->1.
- **$0 and unused rt**: ID_EX_Rt=0 with Rs=0 -> no stall. ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_Uses_Rt=0 -> no stall.
- **Branch beats load-use**: EX_Branch_Taken=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; Stall_Cycles unchanged.
- **Memory wait**: MemAccess=1, Dmem_Ready low for 3 cycles then high -> Pipe_Freeze high for 4 cycles, state back to RUN, Stall_Cycles=4, Mem_Error=0.
- **Timeout**: MEM_TIMEOUT=4, Dmem_Ready held 0 -> 5 frozen cycles, then Mem_Error=1 and it stays 1. Async reset mid-wait clears Mem_Error, state and counters immediately.
- **Saturation**: CNT_W=4, 20 stall cycles -> Stall_Cycles holds 4'hF.
